// File: rtl/clct_seq_sorter_if.sv
// Handshake and candidate/result bus for the sequential first/second CLCT sorter.
// The master side requests a sort and supplies the seven CFEB candidates;
// the slave side (the sorter) reports busy/done and the two selected CLCTs.
interface clct_seq_sorter_if #(
    parameter int MXCFEB = 7,
    parameter int MXPATB = 7,
    parameter int MXKEYB = 5,
    parameter int MXQSB  = 2,
    parameter int MXQLTB = 6,
    parameter int MXBNDB = 4
);
    logic                       start;
    logic [MXCFEB*MXPATB-1:0]   pat_in;
    logic [MXCFEB*MXKEYB-1:0]   key_in;
    logic [MXCFEB*MXQSB-1:0]    qs_in;
    logic [MXCFEB*MXQLTB-1:0]   qlt_in;
    logic [MXCFEB*MXBNDB-1:0]   bend_in;

    logic                       busy;
    logic                       done;

    logic                       clct1_vld;
    logic [MXPATB-1:0]          clct1_pat;
    logic [7:0]                 clct1_key;
    logic [8:0]                 clct1_qkey;
    logic [MXQLTB-1:0]          clct1_qlt;
    logic [MXBNDB-1:0]          clct1_bend;

    logic                       clct2_vld;
    logic [MXPATB-1:0]          clct2_pat;
    logic [7:0]                 clct2_key;
    logic [8:0]                 clct2_qkey;
    logic [MXQLTB-1:0]          clct2_qlt;
    logic [MXBNDB-1:0]          clct2_bend;

    modport master (
        output start, pat_in, key_in, qs_in, qlt_in, bend_in,
        input  busy, done,
        input  clct1_vld, clct1_pat, clct1_key, clct1_qkey, clct1_qlt, clct1_bend,
        input  clct2_vld, clct2_pat, clct2_key, clct2_qkey, clct2_qlt, clct2_bend
    );

    modport slave (
        input  start, pat_in, key_in, qs_in, qlt_in, bend_in,
        output busy, done,
        output clct1_vld, clct1_pat, clct1_key, clct1_qkey, clct1_qlt, clct1_bend,
        output clct2_vld, clct2_pat, clct2_key, clct2_qkey, clct2_qlt, clct2_bend
    );
endinterface

// File: rtl/clct_seq_sorter.sv
// Time-multiplexed first/second CLCT selector.
// Seven CFEB candidates are latched on start, then one shared comparator walks
// them twice: pass 1 picks the best CLCT, pass 2 picks the best CLCT lying
// outside a halfstrip busy window around the first. Results appear with a
// one-cycle done pulse 14 clocks after start and hold until the next done.
module clct_seq_sorter #(
    parameter int MXCFEB     = 7,
    parameter int MXPATB     = 7,
    parameter int MXKEYB     = 5,
    parameter int MXQSB      = 2,
    parameter int MXQLTB     = 6,
    parameter int MXBNDB     = 4,
    parameter int PID_THRESH = 1,
    parameter int BUSY_HW    = 5
) (
    input logic              clock,
    input logic              global_reset,
    clct_seq_sorter_if.slave bus
);

    localparam int         SKEYB    = MXPATB - 1;
    localparam logic [2:0] LAST_IDX = 3'(MXCFEB - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN1,
        SCAN2
    } state_t;

    state_t state;
    logic [2:0] idx;

    logic [MXPATB-1:0] pat_r  [MXCFEB];
    logic [MXKEYB-1:0] key_r  [MXCFEB];
    logic [MXQSB-1:0]  qs_r   [MXCFEB];
    logic [MXQLTB-1:0] qlt_r  [MXCFEB];
    logic [MXBNDB-1:0] bend_r [MXCFEB];

    logic             run_vld;
    logic [SKEYB-1:0] run_key;
    logic [2:0]       run_idx;

    logic       best1_vld;
    logic [2:0] best1_idx;
    logic [7:0] hs1;

    logic [SKEYB-1:0] cur_key;
    logic [7:0]       cur_hs;
    logic [7:0]       hs_diff;
    logic             cur_valid;
    logic             skip;
    logic             take;
    logic             win_vld;
    logic [2:0]       win_idx;
    logic [7:0]       win_hs;
    logic             clct2_ok;

    // Quarter-strip key: twice the full halfstrip plus the signed offset, clamped to 0..447.
    function automatic logic [8:0] calc_qkey(input logic [7:0] hs, input logic [MXQSB-1:0] qs);
        logic [10:0] sum;
        sum = {2'b00, hs, 1'b0} + {{(11-MXQSB){qs[MXQSB-1]}}, qs};
        if (sum[10])
            return 9'd0;
        else if (sum > 11'd447)
            return 9'd447;
        else
            return sum[8:0];
    endfunction

    // Single shared comparator: decides whether the candidate at idx beats the running best.
    always_comb begin
        cur_key   = pat_r[idx][MXPATB-1:1];
        cur_hs    = {idx, key_r[idx]};
        hs_diff   = (cur_hs >= hs1) ? (cur_hs - hs1) : (hs1 - cur_hs);
        cur_valid = (cur_key >= SKEYB'(PID_THRESH));
        skip      = (state == SCAN2) && ((idx == best1_idx) || (hs_diff <= 8'(BUSY_HW)));
        take      = cur_valid && !skip && (!run_vld || (cur_key > run_key));
        win_vld   = run_vld || take;
        win_idx   = take ? idx : run_idx;
        win_hs    = {win_idx, key_r[win_idx]};
        clct2_ok  = best1_vld && win_vld;
    end

    // Sort sequencer: latches candidates, runs both passes and registers the results.
    always_ff @(posedge clock or posedge global_reset) begin
        if (global_reset) begin
            state      <= IDLE;
            idx        <= '0;
            run_vld    <= 1'b0;
            run_key    <= '0;
            run_idx    <= '0;
            best1_vld  <= 1'b0;
            best1_idx  <= '0;
            hs1        <= '0;
            for (int n = 0; n < MXCFEB; n++) begin
                pat_r[n]  <= '0;
                key_r[n]  <= '0;
                qs_r[n]   <= '0;
                qlt_r[n]  <= '0;
                bend_r[n] <= '0;
            end
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.clct1_vld  <= 1'b0;
            bus.clct1_pat  <= '0;
            bus.clct1_key  <= '0;
            bus.clct1_qkey <= '0;
            bus.clct1_qlt  <= '0;
            bus.clct1_bend <= '0;
            bus.clct2_vld  <= 1'b0;
            bus.clct2_pat  <= '0;
            bus.clct2_key  <= '0;
            bus.clct2_qkey <= '0;
            bus.clct2_qlt  <= '0;
            bus.clct2_bend <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int n = 0; n < MXCFEB; n++) begin
                            pat_r[n]  <= bus.pat_in[n*MXPATB +: MXPATB];
                            key_r[n]  <= bus.key_in[n*MXKEYB +: MXKEYB];
                            qs_r[n]   <= bus.qs_in[n*MXQSB +: MXQSB];
                            qlt_r[n]  <= bus.qlt_in[n*MXQLTB +: MXQLTB];
                            bend_r[n] <= bus.bend_in[n*MXBNDB +: MXBNDB];
                        end
                        idx      <= '0;
                        run_vld  <= 1'b0;
                        run_key  <= '0;
                        run_idx  <= '0;
                        bus.busy <= 1'b1;
                        state    <= SCAN1;
                    end
                end

                SCAN1: begin
                    if (idx == LAST_IDX) begin
                        best1_vld <= win_vld;
                        best1_idx <= win_idx;
                        hs1       <= win_hs;
                        run_vld   <= 1'b0;
                        run_key   <= '0;
                        run_idx   <= '0;
                        idx       <= '0;
                        state     <= SCAN2;
                    end else begin
                        if (take) begin
                            run_vld <= 1'b1;
                            run_key <= cur_key;
                            run_idx <= idx;
                        end
                        idx <= idx + 3'd1;
                    end
                end

                SCAN2: begin
                    if (idx == LAST_IDX) begin
                        bus.clct1_vld  <= best1_vld;
                        bus.clct1_pat  <= best1_vld ? pat_r[best1_idx] : '0;
                        bus.clct1_key  <= best1_vld ? hs1 : '0;
                        bus.clct1_qkey <= best1_vld ? calc_qkey(hs1, qs_r[best1_idx]) : '0;
                        bus.clct1_qlt  <= best1_vld ? qlt_r[best1_idx] : '0;
                        bus.clct1_bend <= best1_vld ? bend_r[best1_idx] : '0;
                        bus.clct2_vld  <= clct2_ok;
                        bus.clct2_pat  <= clct2_ok ? pat_r[win_idx] : '0;
                        bus.clct2_key  <= clct2_ok ? win_hs : '0;
                        bus.clct2_qkey <= clct2_ok ? calc_qkey(win_hs, qs_r[win_idx]) : '0;
                        bus.clct2_qlt  <= clct2_ok ? qlt_r[win_idx] : '0;
                        bus.clct2_bend <= clct2_ok ? bend_r[win_idx] : '0;
                        bus.done       <= 1'b1;
                        bus.busy       <= 1'b0;
                        idx            <= '0;
                        state          <= IDLE;
                    end else begin
                        if (take) begin
                            run_vld <= 1'b1;
                            run_key <= cur_key;
                            run_idx <= idx;
                        end
                        idx <= idx + 3'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
